// File: rtl/direct_cache_pkg.sv
// direct_cache_pkg: state encoding plus address-field and byte-merge helpers for direct_cache_wb.
package direct_cache_pkg;

   localparam int ADDR_MAX_W = 64;
   // Widest line the merge helper handles: OFFSET_W up to 10.
   localparam int LINE_MAX_W = 8192;

   typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, REFILL} state_t;

   function automatic logic [ADDR_MAX_W-1:0] addr_tag(input logic [ADDR_MAX_W-1:0] a,
                                                      input int addr_w, input int index_w,
                                                      input int offset_w);
      return (a & ((64'd1 << addr_w) - 64'd1)) >> (index_w + offset_w);
   endfunction

   function automatic logic [ADDR_MAX_W-1:0] addr_index(input logic [ADDR_MAX_W-1:0] a,
                                                        input int index_w, input int offset_w);
      return (a >> offset_w) & ((64'd1 << index_w) - 64'd1);
   endfunction

   function automatic logic [ADDR_MAX_W-1:0] addr_offset(input logic [ADDR_MAX_W-1:0] a,
                                                         input int offset_w);
      return a & ((64'd1 << offset_w) - 64'd1);
   endfunction

   function automatic logic [LINE_MAX_W-1:0] merge_byte(input logic [LINE_MAX_W-1:0] line,
                                                        input int off, input logic [7:0] b);
      logic [LINE_MAX_W-1:0] r;
      r = line;
      r[8*off +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/direct_cache_store.sv
// direct_cache_store: tag/valid/dirty/data arrays with one read and one write port.
module direct_cache_store #(
   parameter int INDEX_W = 8,
   parameter int TAG_W   = 16,
   parameter int LINE_W  = 2048
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INDEX_W-1:0] i_rd_idx,
   output logic [TAG_W-1:0]   o_tag,
   output logic [LINE_W-1:0]  o_line,
   output logic               o_valid,
   output logic               o_dirty,
   input  logic               i_we,
   input  logic [INDEX_W-1:0] i_wr_idx,
   input  logic [TAG_W-1:0]   i_tag,
   input  logic [LINE_W-1:0]  i_line,
   input  logic               i_dirty
);
   logic [TAG_W-1:0]      r_tag  [2**INDEX_W];
   logic [LINE_W-1:0]     r_data [2**INDEX_W];
   logic [2**INDEX_W-1:0] r_valid, r_dirty;

   // Only the state bits clear on reset; tag and data contents survive it.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_we) begin
         r_valid[i_wr_idx] <= 1'b1;
         r_dirty[i_wr_idx] <= i_dirty;
      end

   always_ff @(posedge clk)
      if (i_we) begin
         r_tag[i_wr_idx]  <= i_tag;
         r_data[i_wr_idx] <= i_line;
      end

   assign o_tag   = r_tag[i_rd_idx];
   assign o_line  = r_data[i_rd_idx];
   assign o_valid = r_valid[i_rd_idx];
   assign o_dirty = r_dirty[i_rd_idx];
endmodule

// File: rtl/direct_cache_wb.sv
// direct_cache_wb: direct-mapped write-back/write-allocate byte cache with full-line
// memory refill/writeback and first-lookup hit/miss counters.
module direct_cache_wb
   import direct_cache_pkg::*;
#(
   parameter  int ADDR_W   = 32,
   parameter  int INDEX_W  = 8,
   parameter  int OFFSET_W = 8,
   parameter  int CNT_W    = 32,
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
   localparam int LINE_W   = 8 * (2 ** OFFSET_W)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cpu_req,
   input  logic                       cpu_we,
   input  logic [ADDR_W-1:0]          cpu_addr,
   input  logic [7:0]                 cpu_wdata,
   output logic [7:0]                 cpu_rdata,
   output logic                       cpu_done,
   output logic                       cpu_busy,
   output logic                       hit,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [ADDR_W-OFFSET_W-1:0] mem_addr,
   output logic [LINE_W-1:0]          mem_wdata,
   input  logic [LINE_W-1:0]          mem_rdata,
   input  logic                       mem_ack,
   output logic [CNT_W-1:0]           hit_count,
   output logic [CNT_W-1:0]           miss_count
);
   state_t                r_state;
   logic                  r_we, r_relook;
   logic [TAG_W-1:0]      r_tag;
   logic [INDEX_W-1:0]    r_idx;
   logic [OFFSET_W-1:0]   r_off;
   logic [7:0]            r_wdata;
   logic [ADDR_MAX_W-1:0] w_addr;
   logic [TAG_W-1:0]      w_rd_tag, w_st_tag;
   logic [LINE_W-1:0]     w_rd_line, w_st_line, w_merged;
   logic                  w_rd_valid, w_rd_dirty, w_hit, w_st_we, w_st_dirty;

   assign w_addr   = ADDR_MAX_W'(cpu_addr);
   assign w_hit    = w_rd_valid && (w_rd_tag == r_tag);
   assign w_merged = LINE_W'(merge_byte(LINE_MAX_W'(w_rd_line), int'(r_off), r_wdata));

   // One write port serves write-hit merge, writeback dirty clear and refill fill.
   assign w_st_we    = (r_state == LOOKUP && w_hit && r_we) || (r_state == WRITEBACK && mem_ack) ||
                       (r_state == REFILL && mem_req && mem_ack);
   assign w_st_tag   = (r_state == WRITEBACK) ? w_rd_tag : r_tag;
   assign w_st_line  = (r_state == LOOKUP) ? w_merged : (r_state == WRITEBACK) ? w_rd_line : mem_rdata;
   assign w_st_dirty = (r_state == LOOKUP);

   direct_cache_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_store (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_rd_idx(r_idx),
      .o_tag   (w_rd_tag),
      .o_line  (w_rd_line),
      .o_valid (w_rd_valid),
      .o_dirty (w_rd_dirty),
      .i_we    (w_st_we),
      .i_wr_idx(r_idx),
      .i_tag   (w_st_tag),
      .i_line  (w_st_line),
      .i_dirty (w_st_dirty)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state    <= IDLE;
         r_we       <= 1'b0;
         r_relook   <= 1'b0;
         r_tag      <= '0;
         r_idx      <= '0;
         r_off      <= '0;
         r_wdata    <= '0;
         cpu_rdata  <= '0;
         cpu_done   <= 1'b0;
         cpu_busy   <= 1'b0;
         hit        <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         cpu_done <= 1'b0;
         hit      <= 1'b0;
         case (r_state)
            IDLE: if (cpu_req) begin
               r_we     <= cpu_we;
               r_tag    <= TAG_W'(addr_tag(w_addr, ADDR_W, INDEX_W, OFFSET_W));
               r_idx    <= INDEX_W'(addr_index(w_addr, INDEX_W, OFFSET_W));
               r_off    <= OFFSET_W'(addr_offset(w_addr, OFFSET_W));
               r_wdata  <= cpu_wdata;
               r_relook <= 1'b0;
               cpu_busy <= 1'b1;
               r_state  <= LOOKUP;
            end
            LOOKUP: if (w_hit) begin
               cpu_done  <= 1'b1;
               hit       <= !r_relook;
               cpu_rdata <= w_rd_line[{r_off, 3'b000} +: 8];
               cpu_busy  <= 1'b0;
               r_state   <= IDLE;
               if (!r_relook) hit_count <= hit_count + CNT_W'(1);
            end else begin
               if (!r_relook) miss_count <= miss_count + CNT_W'(1);
               mem_req   <= 1'b1;
               mem_we    <= w_rd_valid && w_rd_dirty;
               mem_addr  <= (w_rd_valid && w_rd_dirty) ? {w_rd_tag, r_idx} : {r_tag, r_idx};
               mem_wdata <= w_rd_line;
               r_state   <= (w_rd_valid && w_rd_dirty) ? WRITEBACK : REFILL;
            end
            WRITEBACK: if (mem_ack) begin
               mem_req <= 1'b0;
               r_state <= REFILL;
            end
            // Arriving from WRITEBACK with mem_req low: spend one idle cycle, then issue.
            REFILL: if (!mem_req) begin
               mem_req  <= 1'b1;
               mem_we   <= 1'b0;
               mem_addr <= {r_tag, r_idx};
            end else if (mem_ack) begin
               mem_req  <= 1'b0;
               r_relook <= 1'b1;
               r_state  <= LOOKUP;
            end
         endcase
      end
endmodule

// File: tb/tb_direct_cache_wb.sv
// tb_direct_cache_wb: directed stimulus against a line-level behavioural cache model,
// with a memory responder and literal expectations that pin the model.
module tb_direct_cache_wb;
   localparam int ADDR_W   = 32;
   localparam int INDEX_W  = 8;
   localparam int OFFSET_W = 8;
   localparam int CNT_W    = 32;
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINE_W   = 8 * (2 ** OFFSET_W);
   localparam int MA_W     = ADDR_W - OFFSET_W;
   localparam int NLINES   = 2 ** INDEX_W;
   localparam int ACK_LAT  = 2;

   typedef logic [LINE_W-1:0] line_t;
   typedef struct {logic we; logic [MA_W-1:0] addr; line_t line;} tx_t;

   logic              clk = 1'b0, rst_n = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, mem_ack = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [7:0]        cpu_wdata = '0, cpu_rdata;
   logic              cpu_done, cpu_busy, hit, mem_req, mem_we;
   logic [MA_W-1:0]   mem_addr;
   line_t             mem_wdata, mem_rdata = '0;
   logic [CNT_W-1:0]  hit_count, miss_count;

   int checks = 0, errors = 0;

   logic             m_valid [NLINES];
   logic             m_dirty [NLINES];
   logic [TAG_W-1:0] m_tag   [NLINES];
   line_t            m_data  [NLINES];
   line_t            mmem [logic [MA_W-1:0]];
   line_t            dmem [logic [MA_W-1:0]];
   tx_t              exp_q[$], log_q[$];
   logic             exp_hit = 1'b0, exp_we = 1'b0, pending = 1'b0, hold_ack = 1'b0;
   logic [7:0]       exp_rdata = '0;
   int               exp_hc = 0, exp_mc = 0;
   logic             last_hit = 1'b0;
   logic [7:0]       last_rdata = '0;

   direct_cache_wb #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_busy(cpu_busy),
      .hit(hit), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   function automatic line_t base_line(input logic [MA_W-1:0] la);
      line_t l;
      for (int i = 0; i < LINE_W / 8; i++) l[8*i +: 8] = 8'(i) ^ la[7:0] ^ la[15:8] ^ 8'h5A;
      return l;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_line(input string name, input line_t act, input line_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         for (int i = 0; i < LINE_W / 8; i++)
            if (act[8*i +: 8] !== exp[8*i +: 8]) begin
               $display("FAIL %s: byte %0d got %0h expected %0h", name, i, act[8*i +: 8], exp[8*i +: 8]);
               break;
            end
      end
   endtask

   // Model: plain per-line bookkeeping of a write-back, write-allocate direct-mapped cache.
   task automatic access(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] wd,
                         input logic poke, output int lat);
      logic [INDEX_W-1:0] idx;
      logic [TAG_W-1:0]   tag;
      logic [MA_W-1:0]    la, vla;
      int                 off;
      logic               poked;
      @(negedge clk);
      idx = INDEX_W'(a >> OFFSET_W);
      tag = TAG_W'(a >> (OFFSET_W + INDEX_W));
      off = int'(a % (2 ** OFFSET_W));
      la  = MA_W'(a >> OFFSET_W);
      pending = 1'b1;
      exp_we  = we;
      if (m_valid[idx] && m_tag[idx] == tag) begin
         exp_hit = 1'b1;
         exp_hc++;
      end else begin
         exp_hit = 1'b0;
         exp_mc++;
         if (m_valid[idx] && m_dirty[idx]) begin
            vla = {m_tag[idx], idx};
            exp_q.push_back('{1'b1, vla, m_data[idx]});
            mmem[vla] = m_data[idx];
         end
         m_data[idx] = mmem.exists(la) ? mmem[la] : base_line(la);
         exp_q.push_back('{1'b0, la, '0});
         m_tag[idx]   = tag;
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
      end
      if (we) begin
         m_data[idx][8*off +: 8] = wd;
         m_dirty[idx] = 1'b1;
      end
      exp_rdata = m_data[idx][8*off +: 8];
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      @(negedge clk);
      cpu_req = 1'b0;
      lat = 1;
      poked = 1'b0;
      while (!cpu_done && lat < 200) begin
         @(negedge clk);
         lat++;
         if (poked && cpu_req) cpu_req = 1'b0;
         if (poke && !poked && mem_req && !mem_we && !cpu_done) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a ^ 32'h0002_0000; cpu_wdata = 8'hDD;
            poked = 1'b1;
         end
      end
      cpu_req = 1'b0;
      chk("done_within_budget", 64'(cpu_done), 64'(1));
      @(negedge clk);
      pending = 1'b0;
   endtask

   task automatic reset_mid(input logic [ADDR_W-1:0] a);
      int n;
      hold_ack = 1'b1;
      @(negedge clk);
      pending = 1'b1;
      exp_q.push_back('{1'b0, MA_W'(a >> OFFSET_W), '0});
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
      @(negedge clk);
      cpu_req = 1'b0;
      n = 0;
      while (!mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_refill_started", 64'(mem_req), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_req", 64'(mem_req), 64'(0));
      chk("rst_mid_busy", 64'(cpu_busy), 64'(0));
      chk("rst_mid_hit_count", 64'(hit_count), 64'(0));
      chk("rst_mid_miss_count", 64'(miss_count), 64'(0));
      for (int i = 0; i < NLINES; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      exp_hc = 0; exp_mc = 0;
      exp_q.delete();
      hold_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      pending = 1'b0;
   endtask

   // Compare process: CPU-side outputs against the model.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (cpu_done) begin
            chk("done_expected", 64'(pending), 64'(1));
            chk("hit", 64'(hit), 64'(exp_hit));
            if (!exp_we) chk("rdata", 64'(cpu_rdata), 64'(exp_rdata));
            chk("hit_count", 64'(hit_count), 64'(exp_hc));
            chk("miss_count", 64'(miss_count), 64'(exp_mc));
            last_hit   = hit;
            last_rdata = cpu_rdata;
         end else if (!pending) begin
            chk("idle_busy", 64'(cpu_busy), 64'(0));
            chk("idle_counts", {32'(hit_count), 32'(miss_count)}, {32'(exp_hc), 32'(exp_mc)});
         end
      end
   end

   // Memory responder: checks each transaction against the model queue, then acks.
   initial begin
      logic tx_on, tx_bad, acked;
      int   tx_wait;
      tx_t  cur;
      tx_on = 1'b0; tx_bad = 1'b0; acked = 1'b0; tx_wait = 0;
      cur = '{1'b0, '0, '0};
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (!rst_n || !mem_req) tx_on = 1'b0;
         else if (!tx_on) begin
            tx_on = 1'b1; tx_wait = 0; acked = 1'b0;
            tx_bad = (exp_q.size() == 0);
            checks++;
            if (tx_bad) begin
               errors++;
               $display("FAIL unexpected_mem_req: we=%0b addr=%0h with no transaction due", mem_we, mem_addr);
            end else cur = exp_q.pop_front();
            log_q.push_back('{mem_we, mem_addr, mem_wdata});
         end
         if (tx_on && !tx_bad) begin
            chk("mem_we", 64'(mem_we), 64'(cur.we));
            chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
            if (cur.we) chk_line("mem_wdata", mem_wdata, cur.line);
            if (acked) chk("mem_req_drop_after_ack", 64'(mem_req), 64'(0));
            else if (tx_wait == ACK_LAT && !hold_ack) begin
               if (mem_we) dmem[mem_addr] = mem_wdata;
               else mem_rdata = dmem.exists(mem_addr) ? dmem[mem_addr] : base_line(mem_addr);
               mem_ack = 1'b1;
               acked = 1'b1;
            end
            tx_wait++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int    lat;
      line_t pre;
      for (int i = 0; i < NLINES; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = '0;
         m_data[i]  = '0;
      end
      pre = base_line(24'h0001FE);
      pre[8 +: 8] = 8'hA5;
      mmem[24'h0001FE] = pre;
      dmem[24'h0001FE] = pre;

      repeat (3) @(negedge clk);
      chk("rst_done_hit", {62'(0), cpu_done, hit}, 64'(0));
      chk("rst_mem_req_we", {62'(0), mem_req, mem_we}, 64'(0));
      chk("rst_busy", 64'(cpu_busy), 64'(0));
      chk("rst_rdata", 64'(cpu_rdata), 64'(0));
      chk("rst_counts", {32'(hit_count), 32'(miss_count)}, 64'(0));
      rst_n = 1'b1;

      // Cold read miss
      log_q.delete();
      access(1'b0, 32'h0001_FE01, 8'h00, 1'b0, lat);
      chk("cold_tx_count", 64'(log_q.size()), 64'(1));
      chk("cold_refill_addr", 64'(log_q[0].addr), 64'h0001FE);
      chk("cold_refill_we", 64'(log_q[0].we), 64'(0));
      chk("cold_hit", 64'(last_hit), 64'(0));
      chk("cold_rdata", 64'(last_rdata), 64'hA5);
      chk("cold_miss_count", 64'(miss_count), 64'(1));

      // Read hit
      log_q.delete();
      access(1'b0, 32'h0001_FE01, 8'h00, 1'b0, lat);
      chk("hit_latency", 64'(lat), 64'(2));
      chk("hit_flag", 64'(last_hit), 64'(1));
      chk("hit_rdata", 64'(last_rdata), 64'hA5);
      chk("hit_no_mem", 64'(log_q.size()), 64'(0));
      chk("hit_hit_count", 64'(hit_count), 64'(1));

      // Write hit, then dirty eviction
      access(1'b1, 32'h0001_FE10, 8'h3C, 1'b0, lat);
      chk("wr_hit_latency", 64'(lat), 64'(2));
      log_q.delete();
      access(1'b0, 32'h0002_FE00, 8'h00, 1'b0, lat);
      chk("evict_tx_count", 64'(log_q.size()), 64'(2));
      chk("evict_wb_we", 64'(log_q[0].we), 64'(1));
      chk("evict_wb_addr", 64'(log_q[0].addr), 64'h0001FE);
      chk("evict_wb_byte16", 64'(log_q[0].line[8*16 +: 8]), 64'h3C);
      chk("evict_refill_addr", 64'(log_q[1].addr), 64'h0002FE);
      chk("evict_refill_we", 64'(log_q[1].we), 64'(0));

      // Evicted line comes back from memory with the written byte
      log_q.delete();
      access(1'b0, 32'h0001_FE10, 8'h00, 1'b0, lat);
      chk("reload_clean_victim_tx", 64'(log_q.size()), 64'(1));
      chk("reload_rdata", 64'(last_rdata), 64'h3C);

      // Write miss allocate with a foreign request pulsed during REFILL
      log_q.delete();
      access(1'b1, 32'h0005_0003, 8'h77, 1'b1, lat);
      chk("wmiss_tx_count", 64'(log_q.size()), 64'(1));
      chk("wmiss_refill_addr", 64'(log_q[0].addr), 64'h000500);
      repeat (3) @(negedge clk);
      chk("busy_req_ignored", 64'(cpu_busy), 64'(0));
      chk("busy_miss_count", 64'(miss_count), 64'(4));
      log_q.delete();
      access(1'b0, 32'h0005_0003, 8'h00, 1'b0, lat);
      chk("wmiss_readback_hit", 64'(last_hit), 64'(1));
      chk("wmiss_readback_rdata", 64'(last_rdata), 64'h77);
      chk("wmiss_readback_latency", 64'(lat), 64'(2));

      // Write miss over a dirty victim
      log_q.delete();
      access(1'b1, 32'h0009_0001, 8'h11, 1'b0, lat);
      chk("wmiss_dirty_tx_count", 64'(log_q.size()), 64'(2));
      chk("wmiss_dirty_wb_addr", 64'(log_q[0].addr), 64'h000500);
      chk("wmiss_dirty_wb_byte3", 64'(log_q[0].line[8*3 +: 8]), 64'h77);
      chk("wmiss_dirty_refill_addr", 64'(log_q[1].addr), 64'h000900);
      access(1'b0, 32'h0009_0001, 8'h00, 1'b0, lat);
      chk("merged_byte", 64'(last_rdata), 64'h11);
      access(1'b0, 32'h0009_0003, 8'h00, 1'b0, lat);
      chk("refilled_byte", 64'(last_rdata), 64'h50);

      // Top index and top offset
      access(1'b0, 32'hFFFF_FFFF, 8'h00, 1'b0, lat);
      chk("top_addr_rdata", 64'(last_rdata), 64'hA5);
      access(1'b1, 32'h0000_00FF, 8'hEE, 1'b0, lat);
      access(1'b0, 32'h0000_00FF, 8'h00, 1'b0, lat);
      chk("offset_ff_rdata", 64'(last_rdata), 64'hEE);

      // Reset during a refill
      reset_mid(32'h0003_1100);
      log_q.delete();
      access(1'b0, 32'h0003_1100, 8'h00, 1'b0, lat);
      chk("post_rst_miss", 64'(last_hit), 64'(0));
      chk("post_rst_miss_count", 64'(miss_count), 64'(1));
      chk("post_rst_hit_count", 64'(hit_count), 64'(0));
      access(1'b0, 32'h0001_FE10, 8'h00, 1'b0, lat);
      chk("post_rst_invalidated", 64'(last_hit), 64'(0));
      chk("post_rst_rdata", 64'(last_rdata), 64'h3C);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/direct_cache_wb.md
Name: direct_cache_wb

Overview:
- Parametrised direct-mapped, byte-addressable cache with a request/acknowledge CPU port and a full-line memory refill/writeback port.
- Successor to the fixed 32-bit / 256-line / 256-byte-line direct-mapped cache. Adds valid and dirty bits, writes, write-back/write-allocate policy, a miss FSM and hit/miss counters.
- Sits between the CPU load/store path and main memory.

Parameters:
- ADDR_W, 32, physical byte-address width.
- INDEX_W, 8, log2 of the number of cache lines.
- OFFSET_W, 8, log2 of bytes per line. Line width LINE_W = 8*2^OFFSET_W (2048 by default).
- TAG_W, ADDR_W-INDEX_W-OFFSET_W, derived; not overridable.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = byte write, 0 = byte read.
- cpu_addr  in  ADDR_W  byte address: tag [ADDR_W-1 -: TAG_W], index [OFFSET_W +: INDEX_W], offset [OFFSET_W-1:0].
- cpu_wdata  in  8  write byte.
- cpu_rdata  out  8  read byte; valid only while cpu_done=1.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high in every state other than IDLE.
- hit  out  1  pulses together with cpu_done when the first lookup hit.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = writeback, 0 = refill.
- mem_addr  out  ADDR_W-OFFSET_W  line address.
- mem_wdata  out  LINE_W  victim line during writeback.
- mem_rdata  in  LINE_W  refill line; sampled when mem_ack=1.
- mem_ack  in  1  one-cycle completion from memory.
- hit_count  out  CNT_W  number of first-lookup hits.
- miss_count  out  CNT_W  number of first-lookup misses.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; all valid and dirty bits = 0.
  - cpu_done, hit, mem_req, mem_we, cpu_busy = 0; cpu_rdata = 0.
  - hit_count = miss_count = 0.
  - Tag and data arrays are not reset.
- IDLE: on cpu_req=1, capture we/addr/wdata into request registers and go to LOOKUP. Inputs are ignored in all other states.
- LOOKUP: hit = valid[idx] && tag[idx]==req_tag.
  - Hit, read: cpu_rdata = line byte at offset; cpu_done=1, hit=1; go to IDLE. Latency is 2 cycles from the cpu_req edge.
  - Hit, write: merge the byte into the line, set dirty[idx]; cpu_done=1, hit=1; go to IDLE.
  - Miss, dirty victim (valid && dirty): go to WRITEBACK.
  - Miss, otherwise: go to REFILL.
  - Counters: hit_count or miss_count increments only on the first LOOKUP of a request. The re-lookup after a refill increments neither and drives hit=0 with cpu_done=1.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={victim tag, idx}, mem_wdata = victim line. All held stable until mem_ack.
  - On mem_ack: clear dirty[idx], drop mem_req, go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={req_tag, idx}.
  - On mem_ack: write mem_rdata to the line, tag=req_tag, valid=1, dirty=0; go to LOOKUP, which then always hits.
  - Write miss therefore allocates, then merges and sets dirty.
- mem_req drops the cycle after mem_ack is sampled. There are no back-to-back memory transactions without a deassert cycle.
- mem_ack in IDLE or LOOKUP is ignored.
- cpu_req asserted in the same cycle as cpu_done is not accepted, because the FSM is still in LOOKUP. It must be held, and is taken the next cycle in IDLE.
- Counters wrap modulo 2^CNT_W.
- Reset mid-WRITEBACK or mid-REFILL aborts the transaction: mem_req drops asynchronously and all lines are invalidated. Dirty data is lost by design.

Decomposition:
- Package direct_cache_pkg holds:
  - the state encoding (IDLE, LOOKUP, WRITEBACK, REFILL);
  - field-extraction functions for tag, index and offset, taking ADDR_W, INDEX_W and OFFSET_W;
  - a byte-merge function (line, offset, byte) returning the merged line.
- One sub-module, direct_cache_store: the tag, valid, dirty and data arrays, with a single read port and a single write port. It owns the asynchronous clear of the valid and dirty bits.
- The FSM and counters stay in direct_cache_wb.

Test Plan:
- Cold read: reset, read 0x0001_FE01 → REFILL with mem_addr=0x0001FE; ack with byte[1]=0xA5 → cpu_done, hit=0, cpu_rdata=0xA5, miss_count=1.
- Read hit: repeat read 0x0001_FE01 → cpu_done 2 cycles after the request, hit=1, rdata=0xA5, no mem_req, hit_count=1.
- Write hit then dirty eviction: write 0x3C to 0x0001_FE10 (hit, dirty); read 0x0002_FE00 → WRITEBACK with mem_addr=0x0001FE and mem_wdata byte[16]=0x3C; then REFILL with mem_addr=0x0002FE.
- Write miss allocate: write 0x77 to 0x0005_0003 → REFILL of line 0x000500, then dirty set; read back 0x0005_0003 → hit, rdata=0x77.
- Request while busy: pulse cpu_req during REFILL with a different address → ignored; only the original request completes and counts.
- Reset mid-refill: assert rst_n=0 while mem_req=1 → mem_req=0 immediately, counters 0; the next read of the same address misses.
